// File: rtl/if_stage_if.sv
// Bus between the instruction-fetch stage and its environment: hazard controls,
// instruction memory port, IF/ID register outputs and performance counters.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  // The environment (hazard unit, branch resolution, instruction memory) drives the stage.
  modport master (
    output stall, flush, redirect, redirect_pc, im_data,
    input  im_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count, stall_count
  );

  modport slave (
    input  stall, flush, redirect, redirect_pc, im_data,
    output im_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count, stall_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, RUN/HALT fetch FSM and the IF/ID register.
// Define IF_STAGE_PERF_CNT_EN to build the fetch and stall performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic     clk,
  input  logic     reset,
  if_stage_if.slave bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        is_halt_word;
  logic        squash;
  logic        load_valid;

  assign pc_plus4     = pc + 32'd4;
  assign redirect_tgt = bus.redirect_pc & ~32'h3;
  assign is_halt_word = (bus.im_data == HALT_WORD);
  assign squash       = bus.flush | bus.redirect;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (!bus.redirect && !bus.stall && !bus.flush && is_halt_word) state_nxt = HALT;
      HALT: if (bus.redirect) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    bus.im_addr = pc;
    bus.halted  = (state == HALT);
    load_valid  = (state == RUN) && !squash && !bus.stall;
  end

  // Next PC: a redirect wins in either state; otherwise HALT and stalls hold.
  always_comb begin
    pc_nxt = pc;
    if (bus.redirect)                                      pc_nxt = redirect_tgt;
    else if (state == RUN && !bus.stall && !is_halt_word)  pc_nxt = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_nxt;
  end

  // IF/ID register: squash beats stall, stall beats load; HALT feeds bubbles.
  always_ff @(posedge clk) begin
    if (reset || squash || (!bus.stall && state == HALT)) begin
      bus.if_id_instr <= 32'h0;
      bus.if_id_pc4   <= 32'h0;
      bus.if_id_valid <= 1'b0;
    end else if (load_valid) begin
      bus.if_id_instr <= bus.im_data;
      bus.if_id_pc4   <= pc_plus4;
      bus.if_id_valid <= 1'b1;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (load_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bus.stall)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.fetch_count = 32'h0;
  assign bus.stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// hazard traffic, all compared against a cycle-level behavioural model.
module tb_if_stage;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: a table for the low 256 bytes, a pattern above that.
  logic [31:0] mem [0:63];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return {a[31:2], 2'b01};
  endfunction

  always_comb begin
    if (bus.im_addr < 32'd256) bus.im_data = mem[bus.im_addr[7:2]];
    else                       bus.im_data = {bus.im_addr[31:2], 2'b01};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
  logic        m_valid, m_halted;

  task automatic check_all(input string tag);
    check({tag, ".im_addr"}, bus.im_addr, m_pc);
    check({tag, ".instr"},   bus.if_id_instr, m_instr);
    check({tag, ".pc4"},     bus.if_id_pc4, m_pc4);
    check({tag, ".valid"},   {31'h0, bus.if_id_valid}, {31'h0, m_valid});
    check({tag, ".halted"},  {31'h0, bus.halted}, {31'h0, m_halted});
`ifdef IF_STAGE_PERF_CNT_EN
    check({tag, ".fcnt"},    bus.fetch_count, m_fcnt);
    check({tag, ".scnt"},    bus.stall_count, m_scnt);
`else
    check({tag, ".fcnt"},    bus.fetch_count, 32'h0);
    check({tag, ".scnt"},    bus.stall_count, 32'h0);
`endif
  endtask

  // One clock: apply inputs, advance the model by the stage's rules, compare.
  task automatic cycle(input string tag, input logic st, input logic fl,
                       input logic rd, input logic [31:0] rpc, input logic rs);
    logic [31:0] word, npc, ninstr, npc4, nf, ns;
    logic        nvalid, nhalt;
    reset           = rs;
    bus.stall       = st;
    bus.flush       = fl;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    word   = mem_word(m_pc);
    npc    = m_pc;
    ninstr = m_instr; npc4 = m_pc4; nvalid = m_valid;
    nhalt  = m_halted;
    nf     = m_fcnt;  ns = m_scnt;
    if (rs) begin
      npc = RESET_PC; ninstr = 0; npc4 = 0; nvalid = 0; nhalt = 0; nf = 0; ns = 0;
    end else begin
      if (rd)                                      npc = {rpc[31:2], 2'b00};
      else if (!m_halted && !st && word != HALT_WORD) npc = m_pc + 4;
      if (fl || rd)          begin ninstr = 0; npc4 = 0; nvalid = 0; end
      else if (st)           begin end
      else if (!m_halted)    begin ninstr = word; npc4 = m_pc + 4; nvalid = 1; nf = nf + 1; end
      else                   begin ninstr = 0; npc4 = 0; nvalid = 0; end
      if (m_halted) nhalt = !rd;
      else          nhalt = (word == HALT_WORD) && !st && !fl && !rd;
      if (st) ns = ns + 1;
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_instr = ninstr; m_pc4 = npc4; m_valid = nvalid;
    m_halted = nhalt; m_fcnt = nf; m_scnt = ns;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom();
      if (mem[i] == HALT_WORD) mem[i] = 32'h1234_5678;
    end
    mem[0]  = 32'h11;
    mem[1]  = 32'h22;
    mem[2]  = 32'h33;
    mem[4]  = HALT_WORD;   // address 0x10
    mem[40] = HALT_WORD;   // address 0xA0
    m_pc = 32'hDEAD_BEEF; m_instr = 'x; m_pc4 = 'x; m_valid = 'x; m_halted = 'x;
    m_fcnt = 'x; m_scnt = 'x;

    cycle("reset0", 1, 1, 1, 32'h80, 1);
    cycle("reset1", 0, 0, 0, 0, 1);

    // Straight-line fetch
    cycle("seq1", 0, 0, 0, 0, 0);
    check("seq1.instr_k", bus.if_id_instr, 32'h11);
    cycle("seq2", 0, 0, 0, 0, 0);
    check("seq2.instr_k", bus.if_id_instr, 32'h22);
    check("seq2.pc4_k",   bus.if_id_pc4, 32'h8);
    check("seq2.addr_k",  bus.im_addr, 32'h8);

    // Two stall cycles at PC=8
    cycle("stall1", 1, 0, 0, 0, 0);
    cycle("stall2", 1, 0, 0, 0, 0);
    check("stall2.addr_k",  bus.im_addr, 32'h8);
    check("stall2.instr_k", bus.if_id_instr, 32'h22);
    cycle("post_stall", 0, 0, 0, 0, 0);

    // Redirect with unaligned target at PC=12
    cycle("redir", 0, 0, 1, 32'h43, 0);
    check("redir.addr_k", bus.im_addr, 32'h40);
    cycle("redir_fetch", 0, 0, 0, 0, 0);
    check("redir_fetch.instr_k", bus.if_id_instr, mem[16]);

    // Halt at 0x10, bubbles while halted, redirect recovery to 0
    cycle("to_halt", 0, 0, 1, 32'h10, 0);
    cycle("halt_in", 0, 0, 0, 0, 0);
    check("halt_in.instr_k", bus.if_id_instr, HALT_WORD);
    check("halt_in.halted_k", {31'h0, bus.halted}, 32'h1);
    cycle("halt_b1", 0, 0, 0, 0, 0);
    cycle("halt_b2", 1, 0, 0, 0, 0);
    cycle("halt_out", 0, 0, 1, 32'h0, 0);
    check("halt_out.addr_k", bus.im_addr, 32'h0);
    cycle("resume1", 0, 0, 0, 0, 0);
    cycle("resume2", 0, 0, 0, 0, 0);

    // Stall with flush, then reset while halted
    cycle("stfl", 1, 1, 0, 0, 0);
    check("stfl.valid_k", {31'h0, bus.if_id_valid}, 32'h0);
    cycle("to_halt2", 0, 0, 1, 32'h10, 0);
    cycle("halt2", 0, 0, 0, 0, 0);
    cycle("halt_rst", 1, 0, 0, 0, 1);
    check("halt_rst.halted_k", {31'h0, bus.halted}, 32'h0);
    cycle("after_rst", 0, 0, 0, 0, 0);

    // PC wrap at the top of the address space
    cycle("wrap_redir", 0, 0, 1, 32'hFFFF_FFFF, 0);
    cycle("wrap", 0, 0, 0, 0, 0);
    check("wrap.addr_k", bus.im_addr, 32'h0);
    check("wrap.pc4_k",  bus.if_id_pc4, 32'h0);

    // Random hazard traffic
    for (int i = 0; i < 400; i++) begin
      logic st, fl, rd, rs;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 20);
      fl  = ($urandom_range(0, 99) < 10);
      rd  = ($urandom_range(0, 99) < 12);
      rs  = ($urandom_range(0, 99) < 2);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                        : $urandom_range(0, 255);
      cycle("rand", st, fl, rd, rpc, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard unit: hold PC and IF/ID register.
REQ-006 flush  input  1  squash IF/ID contents (bubble) on next edge.
REQ-007 redirect  input  1  taken branch/jump resolved downstream.
REQ-008 redirect_pc  input  32  target PC for redirect.
REQ-009 im_addr  output  32  byte address to instruction memory, combinationally equal to PC.
REQ-010 im_data  input  32  instruction word returned combinationally by instruction memory.
REQ-011 if_id_instr  output  32  registered instruction to decode.
REQ-012 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-013 if_id_valid  output  1  registered valid flag; 0 marks a bubble.
REQ-014 halted  output  1  high while the fetch FSM is in HALT.
REQ-015 fetch_count  output  32  retired-fetch counter (see Configuration).
REQ-016 stall_count  output  32  stall-cycle counter (see Configuration).

Function
REQ-017 The PC SHALL be a 32-bit register; im_addr SHALL equal the PC with zero combinational latency; the instruction at PC appears in IF/ID one edge later.
REQ-018 The FSM SHALL have states RUN and HALT.
REQ-019 In RUN, next-PC priority SHALL be: redirect -> redirect_pc; else stall -> hold; else im_data==HALT_WORD -> hold; else PC+4.
REQ-020 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0); redirect_pc low two bits SHALL be forced to 0.
REQ-021 IF/ID update priority SHALL be: flush or redirect -> bubble (instr 32'h0, pc4 32'h0, valid 0); else stall -> hold; else in RUN load im_data, PC+4, valid 1; in HALT load bubble.
REQ-022 RUN->HALT SHALL occur when im_data==HALT_WORD with no stall, flush or redirect that cycle; the halt word itself SHALL be latched into IF/ID with valid 1.
REQ-023 In HALT the PC SHALL hold; HALT->RUN SHALL occur only on redirect (wrong-path recovery), loading redirect_pc into PC the same edge.
REQ-024 Stall and flush asserted together SHALL yield a bubble with PC held.
REQ-025 halted SHALL be a registered output equal to (state==HALT).

Reset
REQ-026 On reset asserted at an edge: PC=RESET_PC, state=RUN, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, both counters=0, regardless of other inputs.
REQ-027 Reset mid-operation (including in HALT or during stall) SHALL take effect at the next edge with no residual state.

Configuration
REQ-028 Macro IF_STAGE_PERF_CNT_EN: when defined, fetch_count SHALL increment on each edge that loads a valid instruction into IF/ID, and stall_count on each edge with stall=1 and reset=0; both wrap modulo 2^32.
REQ-029 When IF_STAGE_PERF_CNT_EN is undefined, fetch_count and stall_count SHALL be constant 0 and no counter registers synthesized; all other behaviour identical.

Verification
REQ-030 Reset, memory words 0x11,0x22,0x33 at 0,4,8, no stalls -> im_addr 0,4,8 on cycles 0,1,2; if_id_instr 0x11,0x22 with pc4 4,8 on cycles 1,2.
REQ-031 stall=1 for 2 cycles at PC=8 -> PC stays 8, IF/ID holds prior word, stall_count=2 (macro on), fetch_count unchanged.
REQ-032 redirect=1, redirect_pc=0x43 at PC=12 -> next PC=0x40, IF/ID bubble (valid 0), then word at 0x40 fetched.
REQ-033 HALT_WORD at address 0x10 -> IF/ID gets HALT_WORD valid 1, halted=1 next cycle, PC stays 0x10, subsequent IF/ID bubbles; redirect to 0x0 -> halted=0, fetch resumes at 0.
REQ-034 stall=1 and flush=1 same cycle -> bubble, PC held; reset asserted in HALT -> PC=RESET_PC, halted=0, valid=0 next edge.
REQ-035 PC forced to 32'hFFFF_FFFC via redirect -> following PC=0, if_id_pc4=0.
